hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline sequencing controller for the 24-bit five-stage processor. It sits beside the instruction decoder and tracks the destination register of every in-flight instruction in EX, MEM and WB. From that state it:
- inserts load-use stalls;
- flushes on taken branches and jumps;
- selects PC source;
- generates EX-stage forwarding selects;
- keeps saturating stall and flush counters for simulation statistics.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  IF/ID register holds a live instruction
- id_instr  in  24  instruction in ID
- branch_taken  in  1  EX-stage branch resolved taken; only meaningful when EX holds a branch
- freeze  in  1  external freeze (memory not ready); holds the whole pipeline
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID register write enable
- flush_ifid  out  1  clear IF/ID to a bubble
- bubble_idex  out  1  load a bubble into ID/EX instead of the decoded instruction
- pc_sel  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- fwd_a  out  2  EX operand A (rs) source: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result
- fwd_b  out  2  EX operand B (rt) source, same encoding
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  flush events, saturating

## Operation
Instruction fields:
- opcode [23:20], rs [19:16], rt [15:12], rd [11:8].

Decode of the ID instruction:
- Source usage: R-type 0001 reads rs and rt. I-type 0010 reads rs. Branch 1000 reads rs and rt. Load 1100 reads rs. Store 0011 reads rs and rt. Jump 0100 reads nothing.
- Destination: R-type writes rd. I-type, load and jump write rt. Branch and store write nothing.
- Any other opcode, or id_valid = 0, is a NOP: no sources, no write.
- All 16 registers are ordinary; r0 is not hardwired.

Tracking registers:
- EX entry: valid, regwrite, memread, dest, rs, rt, use_rs, use_rt, is_branch.
- MEM and WB entries: valid, regwrite, dest.

Hazard rules:
- Load-use: EX valid and memread, and EX.dest equals a used ID source. Then pc_we = 0, ifid_we = 0, bubble_idex = 1, and stall_cnt increments.
- Taken branch: EX.is_branch and branch_taken. Then pc_sel = 01, flush_ifid = 1, bubble_idex = 1, pc_we = 1, and flush_cnt increments.
- Jump in ID: pc_sel = 10, flush_ifid = 1, pc_we = 1. The jump itself proceeds into EX and flush_cnt increments.

Priority, highest first:
1. freeze. All tracking registers hold; pc_we = ifid_we = 0; flush_ifid = bubble_idex = 0; pc_sel = 00; counters hold.
2. Taken branch. It squashes ID, so any load-use stall or jump in ID that same cycle is ignored.
3. Load-use stall.
4. Jump.
5. Normal: pc_we = ifid_we = 1, all else 0.

Tracking update on each non-frozen edge:
- EX receives the ID decode, or an empty entry if bubble_idex is asserted.
- MEM receives EX; WB receives MEM.

Forwarding, per EX source that is used:
- MEM valid, regwrite, and dest match → 01.
- Else WB valid, regwrite, and dest match → 10.
- Else 00.
- MEM has priority over WB. An unused source always gets 00.

Counters:
- Increment by 1 per qualifying cycle.
- Saturate at 2^CNT_W − 1.

## Timing
- All tracking registers and counters update on the rising edge of clk.
- Control and forwarding outputs are combinational from tracking state plus id_instr, id_valid, branch_taken and freeze.
- Reset clears every tracking valid bit and both counters, at any time including mid-stall or mid-flush.
- Outputs with rst asserted and id_valid = 0: pc_we = 1, ifid_we = 1, flush_ifid = 0, bubble_idex = 0, pc_sel = 00, fwd_a = fwd_b = 00, counters 0.
- Load-use stall lasts exactly one cycle. Next cycle the load sits in MEM, the consumer is still in ID and no hazard exists.
- Branch penalty is 2 squashed slots (IF/ID plus bubble into EX). Jump penalty is 1 slot.
- branch_taken with EX not holding a branch is ignored.
- Under freeze, branch_taken must be held by its source until freeze drops.

## Test plan
- Load-use stall: apply load 24'hC13000 (r3 ← mem[r1]), then 24'h132501 (r5 = r3 + r2). Required: one cycle of pc_we = 0, ifid_we = 0, bubble_idex = 1 and stall_cnt = 1. When the add reaches EX, fwd_a = 10.
- Back-to-back R-type: apply 24'h112401 (r4 = r1 + r2), then 24'h143601 (r6 = r4 + r3). Required: no stall, and fwd_a = 01 in the second instruction's EX cycle. Add a third instruction reading r4 two slots later; required: fwd_a = 10.
- Taken branch plus stall: branch 24'h812000 in EX with branch_taken = 1 while ID holds a load-use consumer. Required: pc_sel = 01, flush_ifid = 1, bubble_idex = 1, stall_cnt unchanged, flush_cnt +1.
- Jump: jump 24'h400010 in ID. Required: pc_sel = 10 and flush_ifid = 1 for one cycle. The jump enters EX with dest = r0 and regwrite = 1.
- Freeze: assert freeze for 3 cycles mid-stream. Required: tracking registers, counters and the forwarding pattern are unchanged; pc_we = 0 throughout.
- Async reset and saturation: assert rst during a stall, asynchronously to clk. Required: outputs return to reset values immediately. Separately, with CNT_W = 2, force 5 stalls; required: stall_cnt = 3.

Source files
------------

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: pipeline sequencing controller for the 24-bit five-stage core.
// It tracks in-flight destinations in EX/MEM/WB and produces the hazard control,
// the PC source, the EX forwarding selects and saturating stall/flush statistics.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   id_valid      IF/ID holds a live instruction
//   id_instr      instruction in ID (opcode[23:20] rs[19:16] rt[15:12] rd[11:8])
//   branch_taken  EX-stage branch resolved taken
//   freeze        external hold of the whole pipeline
//   pc_we, ifid_we, flush_ifid, bubble_idex, pc_sel   fetch/decode control (combinational)
//   fwd_a, fwd_b  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB (combinational)
//   stall_cnt, flush_cnt   saturating statistics counters (registered)
module hazard_scheduler #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [23:0]      id_instr,
  input  logic             branch_taken,
  input  logic             freeze,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic [1:0]       pc_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned REG_W = 4;

  localparam logic [3:0] OP_RTYPE  = 4'b0001;
  localparam logic [3:0] OP_ITYPE  = 4'b0010;
  localparam logic [3:0] OP_STORE  = 4'b0011;
  localparam logic [3:0] OP_JUMP   = 4'b0100;
  localparam logic [3:0] OP_BRANCH = 4'b1000;
  localparam logic [3:0] OP_LOAD   = 4'b1100;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
    logic             is_branch;
  } ex_entry_t;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic [REG_W-1:0] dest;
  } wb_entry_t;

  ex_entry_t id_dec;
  ex_entry_t ex_q;
  wb_entry_t mem_q;
  wb_entry_t wb_q;
  logic      id_is_jump;
  logic      load_use;
  logic      take_branch;
  logic      stall_evt;
  logic      flush_evt;

  // Decode the ID instruction into the shape of an EX tracking entry.
  always_comb begin
    id_dec     = '0;
    id_is_jump = 1'b0;
    id_dec.rs  = id_instr[19:16];
    id_dec.rt  = id_instr[15:12];
    if (id_valid) begin
      id_dec.valid = 1'b1;
      case (id_instr[23:20])
        OP_RTYPE: begin
          id_dec.use_rs   = 1'b1;
          id_dec.use_rt   = 1'b1;
          id_dec.regwrite = 1'b1;
          id_dec.dest     = id_instr[11:8];
        end
        OP_ITYPE: begin
          id_dec.use_rs   = 1'b1;
          id_dec.regwrite = 1'b1;
          id_dec.dest     = id_instr[15:12];
        end
        OP_BRANCH: begin
          id_dec.use_rs    = 1'b1;
          id_dec.use_rt    = 1'b1;
          id_dec.is_branch = 1'b1;
        end
        OP_LOAD: begin
          id_dec.use_rs   = 1'b1;
          id_dec.regwrite = 1'b1;
          id_dec.memread  = 1'b1;
          id_dec.dest     = id_instr[15:12];
        end
        OP_STORE: begin
          id_dec.use_rs = 1'b1;
          id_dec.use_rt = 1'b1;
        end
        OP_JUMP: begin
          id_dec.regwrite = 1'b1;
          id_dec.dest     = id_instr[15:12];
          id_is_jump      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Hazard detection against the EX entry.
  always_comb begin
    load_use = ex_q.valid && ex_q.memread &&
               ((id_dec.use_rs && (id_dec.rs == ex_q.dest)) ||
                (id_dec.use_rt && (id_dec.rt == ex_q.dest)));
    take_branch = ex_q.valid && ex_q.is_branch && branch_taken;
  end

  // Control outputs in priority order: freeze, taken branch, load-use, jump.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    pc_sel      = PC_SEQ;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    if (freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else if (take_branch) begin
      pc_sel      = PC_BRANCH;
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
      flush_evt   = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      bubble_idex = 1'b1;
      stall_evt   = 1'b1;
    end else if (id_is_jump) begin
      pc_sel     = PC_JUMP;
      flush_ifid = 1'b1;
      flush_evt  = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_pick(input logic used, input logic [REG_W-1:0] src,
                                          input wb_entry_t mem_e, input wb_entry_t wb_e);
    logic [1:0] sel;
    sel = FWD_RF;
    if (used) begin
      if (mem_e.valid && mem_e.regwrite && (mem_e.dest == src)) sel = FWD_MEM;
      else if (wb_e.valid && wb_e.regwrite && (wb_e.dest == src)) sel = FWD_WB;
    end
    return sel;
  endfunction

  // EX operand forwarding; the nearer MEM result wins over WB.
  always_comb begin
    fwd_a = fwd_pick(ex_q.valid && ex_q.use_rs, ex_q.rs, mem_q, wb_q);
    fwd_b = fwd_pick(ex_q.valid && ex_q.use_rt, ex_q.rt, mem_q, wb_q);
  end

  // Tracking pipeline and statistics; everything holds while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      ex_q  <= bubble_idex ? '0 : id_dec;
      mem_q <= {ex_q.valid, ex_q.regwrite, ex_q.dest};
      wb_q  <= mem_q;
      if (stall_evt && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_evt && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: a vector table for the main pipeline
// scenarios plus hand-written async-reset and counter-saturation sequences.
module tb_hazard_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [23:0] id_instr = '0;
  logic        branch_taken = 1'b0;
  logic        freeze = 1'b0;
  logic        pc_we, ifid_we, flush_ifid, bubble_idex;
  logic [1:0]  pc_sel, fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_valid = 1'b0;
  logic [23:0] s_instr = '0;
  logic        s_pc_we, s_ifid_we, s_flush_ifid, s_bubble_idex;
  logic [1:0]  s_pc_sel, s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_scheduler #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .branch_taken(branch_taken), .freeze(freeze),
    .pc_we(pc_we), .ifid_we(ifid_we), .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
    .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_scheduler #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(s_valid), .id_instr(s_instr),
    .branch_taken(1'b0), .freeze(1'b0),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .flush_ifid(s_flush_ifid), .bubble_idex(s_bubble_idex),
    .pc_sel(s_pc_sel), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [23:0] instr;
    logic        bt;
    logic        frz;
    logic [3:0]  ctl;   // {pc_we, ifid_we, flush_ifid, bubble_idex}
    logic [1:0]  sel;
    logic [1:0]  fa;
    logic [1:0]  fb;
    int          s;
    int          f;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [23:0] ins, input logic bt,
                     input logic frz, input logic [3:0] ctl, input logic [1:0] sel,
                     input logic [1:0] fa, input logic [1:0] fb, input int s, input int f);
    vec_t t;
    t.rst = r; t.valid = v; t.instr = ins; t.bt = bt; t.frz = frz;
    t.ctl = ctl; t.sel = sel; t.fa = fa; t.fb = fb; t.s = s; t.f = f;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    // rst valid instr bt frz ctl sel fa fb stall flush
    add(1, 0, 24'h000000, 0, 0, 4'b1100, 0, 0, 0, 0, 0); // reset values
    add(0, 1, 24'hC13000, 0, 0, 4'b1100, 0, 0, 0, 0, 0); // load r3
    add(0, 1, 24'h132501, 0, 0, 4'b0001, 0, 0, 0, 0, 0); // consumer of r3: stall
    add(0, 1, 24'h132501, 0, 0, 4'b1100, 0, 0, 0, 1, 0); // consumer retried, no hazard
    add(0, 0, 24'h000000, 0, 0, 4'b1100, 0, 2, 0, 1, 0); // add in EX gets r3 from WB
    add(0, 1, 24'h112401, 0, 0, 4'b1100, 0, 0, 0, 1, 0); // r4 = r1 + r2
    add(0, 1, 24'h143601, 0, 0, 4'b1100, 0, 0, 0, 1, 0); // r6 = r4 + r3, no stall
    add(0, 1, 24'h147701, 0, 0, 4'b1100, 0, 1, 0, 1, 0); // r4 from MEM
    add(0, 0, 24'h000000, 0, 0, 4'b1100, 0, 2, 0, 1, 0); // third reader: r4 from WB
    add(0, 1, 24'h112401, 0, 0, 4'b1100, 0, 0, 0, 1, 0); // r4 written twice
    add(0, 1, 24'h112401, 0, 0, 4'b1100, 0, 0, 0, 1, 0);
    add(0, 1, 24'h144401, 0, 0, 4'b1100, 0, 0, 0, 1, 0); // reads r4 on both ports
    add(0, 0, 24'h000000, 0, 0, 4'b1100, 0, 1, 1, 1, 0); // MEM beats WB
    add(0, 1, 24'h812000, 0, 0, 4'b1100, 0, 0, 0, 1, 0); // branch in ID
    add(0, 1, 24'h400010, 1, 0, 4'b1111, 1, 0, 0, 1, 0); // taken branch squashes jump
    add(0, 0, 24'h000000, 1, 0, 4'b1100, 0, 0, 0, 1, 1); // taken with no branch in EX
    add(0, 1, 24'h400010, 0, 0, 4'b1110, 2, 0, 0, 1, 1); // jump in ID
    add(0, 1, 24'h110501, 0, 0, 4'b1100, 0, 0, 0, 1, 2); // reader of r0 behind jump
    add(0, 0, 24'h000000, 0, 0, 4'b1100, 0, 0, 1, 1, 2); // jump wrote r0: rt from MEM
    add(0, 1, 24'hC53000, 0, 0, 4'b1100, 0, 0, 0, 1, 2); // load r3 from r5
    add(0, 1, 24'h132501, 0, 1, 4'b0000, 0, 2, 0, 1, 2); // frozen with load-use pending
    add(0, 1, 24'h132501, 0, 1, 4'b0000, 0, 2, 0, 1, 2);
    add(0, 1, 24'h132501, 0, 1, 4'b0000, 0, 2, 0, 1, 2);
    add(0, 1, 24'h132501, 0, 0, 4'b0001, 0, 2, 0, 1, 2); // freeze drops: stall
    add(0, 0, 24'h000000, 0, 0, 4'b1100, 0, 0, 0, 2, 2);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; id_valid = vecs[i].valid; id_instr = vecs[i].instr;
      branch_taken = vecs[i].bt; freeze = vecs[i].frz;
      #1;
      chk("ctl", i, int'({pc_we, ifid_we, flush_ifid, bubble_idex}), int'(vecs[i].ctl));
      chk("pc_sel", i, int'(pc_sel), int'(vecs[i].sel));
      chk("fwd_a", i, int'(fwd_a), int'(vecs[i].fa));
      chk("fwd_b", i, int'(fwd_b), int'(vecs[i].fb));
      chk("stall_cnt", i, int'(stall_cnt), vecs[i].s);
      chk("flush_cnt", i, int'(flush_cnt), vecs[i].f);
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk);
    branch_taken = 1'b0; freeze = 1'b0; id_valid = 1'b1; id_instr = 24'hC13000;
    @(negedge clk);
    id_instr = 24'h132501;
    #1;
    chk("pre_rst_bubble", 100, int'(bubble_idex), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_pc_we", 101, int'(pc_we), 1);
    chk("rst_ifid_we", 101, int'(ifid_we), 1);
    chk("rst_bubble", 101, int'(bubble_idex), 0);
    chk("rst_stall_cnt", 101, int'(stall_cnt), 0);
    chk("rst_flush_cnt", 101, int'(flush_cnt), 0);
    @(negedge clk);
    rst = 1'b0; id_valid = 1'b0;

    // Saturation of both counters with CNT_W = 2.
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_instr = 24'hC13000;
      @(negedge clk);
      s_instr = 24'h132501;
      @(posedge clk);
      #1;
      chk("sat_stall_cnt", 200 + i, int'(s_stall_cnt), (i > 3) ? 3 : i);
    end
    chk("sat_flush_pre", 210, int'(s_flush_cnt), 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_instr = 24'h400010;
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("sat_flush_cnt", 211, int'(s_flush_cnt), 3);
    chk("sat_stall_hold", 212, int'(s_stall_cnt), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
